// File: rtl/fc_mac_array.sv
// Multi-lane fully-connected MAC engine: NUM_LANES neurons share one node stream,
// each with its own weight and bias, followed by optional ReLU, shift and saturation.
module fc_mac_array #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int NUM_LANES      = 4,
  parameter int CNT_WIDTH      = 12,
  parameter int ACC_WIDTH      = 2*IN_DATA_WIDTH+CNT_WIDTH,
  parameter int OUT_DATA_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                i_run,
  input  logic [CNT_WIDTH-1:0]                i_num_inputs,
  input  logic                                i_relu_en,
  input  logic [4:0]                          i_shift,
  input  logic [NUM_LANES*IN_DATA_WIDTH-1:0]  i_bias,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [IN_DATA_WIDTH-1:0]            i_node,
  input  logic [NUM_LANES*IN_DATA_WIDTH-1:0]  i_wegt,
  output logic                                o_valid,
  output logic [NUM_LANES*OUT_DATA_WIDTH-1:0] o_result,
  output logic                                o_idle
);

  localparam int PW = 2*IN_DATA_WIDTH;
  // One extra bit so adding the bias to a full-scale accumulator cannot wrap.
  localparam int SW = ACC_WIDTH+1;
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-OUT_DATA_WIDTH+1){1'b0}}, {(OUT_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-OUT_DATA_WIDTH+1){1'b1}}, {(OUT_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN1 = 2'd2,
    DRAIN2 = 2'd3
  } state_t;

  state_t                               state_r;
  logic [CNT_WIDTH-1:0]                 cnt_r;
  logic [CNT_WIDTH-1:0]                 num_r;
  logic                                 relu_r;
  logic [4:0]                           shift_r;
  logic [NUM_LANES*IN_DATA_WIDTH-1:0]   bias_r;
  logic signed [PW-1:0]                 prod_r [NUM_LANES];
  logic                                 prod_vld_r;
  logic signed [ACC_WIDTH-1:0]          acc_r [NUM_LANES];
  logic                                 valid_r;
  logic [NUM_LANES*OUT_DATA_WIDTH-1:0]  result_r;
  logic [NUM_LANES*OUT_DATA_WIDTH-1:0]  post_s;
  logic                                 ready_s;
  logic                                 accept_s;

  function automatic logic [OUT_DATA_WIDTH-1:0] post_proc(
    input logic signed [ACC_WIDTH-1:0]     acc,
    input logic signed [IN_DATA_WIDTH-1:0] bias,
    input logic                            relu,
    input logic [4:0]                      sh
  );
    logic signed [SW-1:0] sum;
    sum = SW'(acc) + SW'(bias);
    if (relu && sum[SW-1]) begin
      sum = '0;
    end else begin
      sum = sum;
    end
    sum = sum >>> sh;
    if (sum > SAT_MAX) begin
      post_proc = SAT_MAX[OUT_DATA_WIDTH-1:0];
    end else if (sum < SAT_MIN) begin
      post_proc = SAT_MIN[OUT_DATA_WIDTH-1:0];
    end else begin
      post_proc = sum[OUT_DATA_WIDTH-1:0];
    end
  endfunction

  assign ready_s  = (state_r == ACCUM) && (cnt_r != num_r);
  assign accept_s = ready_s && i_valid;

  // Per-lane bias, ReLU, shift and saturation of the finished accumulators.
  always_comb begin
    post_s = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      post_s[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] =
        post_proc(acc_r[k], $signed(bias_r[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]), relu_r, shift_r);
    end
  end

  // Job control, product/accumulate pipeline and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      num_r      <= '0;
      relu_r     <= 1'b0;
      shift_r    <= '0;
      bias_r     <= '0;
      prod_vld_r <= 1'b0;
      valid_r    <= 1'b0;
      result_r   <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        prod_r[k] <= '0;
        acc_r[k]  <= '0;
      end
    end else begin
      valid_r    <= 1'b0;
      prod_vld_r <= accept_s;
      if (accept_s) begin
        cnt_r <= cnt_r + CNT_WIDTH'(1);
        for (int k = 0; k < NUM_LANES; k++) begin
          prod_r[k] <= $signed(i_node) * $signed(i_wegt[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]);
        end
      end
      if (prod_vld_r) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          acc_r[k] <= acc_r[k] + ACC_WIDTH'(prod_r[k]);
        end
      end
      case (state_r)
        IDLE: begin
          if (i_run) begin
            num_r      <= i_num_inputs;
            relu_r     <= i_relu_en;
            shift_r    <= i_shift;
            bias_r     <= i_bias;
            cnt_r      <= '0;
            prod_vld_r <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
              prod_r[k] <= '0;
              acc_r[k]  <= '0;
            end
            state_r <= ACCUM;
          end
        end
        ACCUM: begin
          if (cnt_r == num_r) begin
            state_r <= DRAIN1;
          end
        end
        DRAIN1: state_r <= DRAIN2;
        DRAIN2: begin
          // The last product has reached the accumulator by now.
          state_r  <= IDLE;
          valid_r  <= 1'b1;
          result_r <= post_s;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign o_ready  = ready_s;
  assign o_idle   = (state_r == IDLE);
  assign o_valid  = valid_r;
  assign o_result = result_r;

endmodule

// File: tb/tb_fc_mac_array.sv
// Randomised bench for fc_mac_array against a job-level arithmetic model,
// with literal spot checks taken from hand-worked examples.
module tb_fc_mac_array;

  localparam int W  = 16;
  localparam int NL = 4;
  localparam int CW = 12;
  localparam int OW = 16;
  localparam int BW = NL*W;
  localparam int RW = NL*OW;
  localparam longint SMAX = (longint'(1) << (OW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (OW-1));
  localparam int LIMIT = 5000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_run = 1'b0;
  logic [CW-1:0] i_num_inputs = '0;
  logic          i_relu_en = 1'b0;
  logic [4:0]    i_shift = '0;
  logic [BW-1:0] i_bias = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [W-1:0]  i_node = '0;
  logic [BW-1:0] i_wegt = '0;
  logic          o_valid;
  logic [RW-1:0] o_result;
  logic          o_idle;

  fc_mac_array #(
    .IN_DATA_WIDTH(W), .NUM_LANES(NL), .CNT_WIDTH(CW),
    .ACC_WIDTH(2*W+CW), .OUT_DATA_WIDTH(OW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_inputs(i_num_inputs),
    .i_relu_en(i_relu_en), .i_shift(i_shift), .i_bias(i_bias), .i_valid(i_valid),
    .o_ready(o_ready), .i_node(i_node), .i_wegt(i_wegt), .o_valid(o_valid),
    .o_result(o_result), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Job-level model: 0 = idle, 1 = collecting beats, 2 = waiting for the result.
  int            m_phase = 0;
  int            m_wait = 0;
  int            m_n = 0;
  int            m_cnt = 0;
  bit            m_relu = 1'b0;
  int            m_shift = 0;
  longint        m_bias [NL];
  longint        m_acc [NL];
  logic          m_valid = 1'b0;
  logic [RW-1:0] m_result = '0;

  logic [W-1:0]  q_node [$];
  logic [BW-1:0] q_wegt [$];

  function automatic longint lane_in(logic [BW-1:0] v, int k);
    logic signed [W-1:0] t;
    t = v[k*W +: W];
    return longint'(t);
  endfunction

  function automatic longint lane_out(logic [RW-1:0] v, int k);
    logic signed [OW-1:0] t;
    t = v[k*OW +: OW];
    return longint'(t);
  endfunction

  function automatic logic [BW-1:0] pack4(int a, int b, int c, int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [OW-1:0] ref_post(longint acc, longint bias, bit relu, int sh);
    longint s;
    longint p2;
    s  = acc + bias;
    p2 = longint'(1) << sh;
    if (relu && s < 0) s = 0;
    if (s >= 0) s = s / p2;
    else        s = -((-s + p2 - 1) / p2);
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    return s[OW-1:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_lane(input string name, input int k, input longint exp);
    chk({name, "_dut"}, lane_out(o_result, k), exp);
    chk({name, "_model"}, lane_out(m_result, k), exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_n = 0; m_cnt = 0; m_relu = 1'b0; m_shift = 0;
    m_valid = 1'b0; m_result = '0;
    for (int k = 0; k < NL; k++) begin m_acc[k] = 0; m_bias[k] = 0; end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_valid = 1'b0;
    case (m_phase)
      0: if (i_run) begin
        m_n = int'(i_num_inputs); m_relu = i_relu_en; m_shift = int'(i_shift);
        m_cnt = 0;
        for (int k = 0; k < NL; k++) begin m_bias[k] = lane_in(i_bias, k); m_acc[k] = 0; end
        if (m_n == 0) begin m_phase = 2; m_wait = 3; end
        else m_phase = 1;
      end
      1: if (i_valid) begin
        for (int k = 0; k < NL; k++) m_acc[k] += lane_in({48'd0, i_node}, 0) * lane_in(i_wegt, k);
        m_cnt++;
        if (m_cnt == m_n) begin m_phase = 2; m_wait = 3; end
      end
      2: begin
        m_wait--;
        if (m_wait == 0) begin
          m_phase = 0;
          m_valid = 1'b1;
          for (int k = 0; k < NL; k++)
            m_result[k*OW +: OW] = ref_post(m_acc[k], m_bias[k], m_relu, m_shift);
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("o_valid", longint'(o_valid), longint'(m_valid));
    chk("o_idle", longint'(o_idle), longint'(m_phase == 0));
    chk("o_ready", longint'(o_ready), longint'(m_phase == 1));
    chk("o_result", longint'(o_result), longint'(m_result));
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_job(input int n, input bit relu, input int sh, input logic [BW-1:0] bias,
                         input int gap_pct, input bit hold, input bit noise);
    int idx = 0;
    int guard = 0;
    int last_acc;
    bit acc;
    i_run = 1'b1; i_num_inputs = CW'(n); i_relu_en = relu; i_shift = 5'(sh);
    i_bias = bias; i_valid = 1'b0;
    cycle();
    last_acc = cyc;
    i_run = 1'b0; i_num_inputs = CW'($urandom); i_relu_en = 1'($urandom);
    i_shift = 5'($urandom); i_bias = {$urandom, $urandom};
    while (m_phase != 0 && guard < LIMIT) begin
      i_node = W'($urandom); i_wegt = {$urandom, $urandom}; i_valid = 1'b0;
      if (m_phase == 1) begin
        if (int'($urandom_range(0, 99)) >= gap_pct) begin
          i_valid = 1'b1; i_node = q_node[idx]; i_wegt = q_wegt[idx];
        end
      end else if (hold) begin
        i_valid = 1'b1;
      end
      i_run = noise && ($urandom_range(0, 2) == 0);
      acc = i_valid && (m_phase == 1);
      cycle();
      guard++;
      if (acc) begin idx++; last_acc = cyc; end
    end
    i_run = 1'b0; i_valid = 1'b0;
    chk("job_done", longint'(guard < LIMIT), 1);
    chk("latency", cyc - last_acc, 3);
    chk("beats", idx, n);
  endtask

  task automatic load_basic();
    q_node.delete(); q_wegt.delete();
    q_node.push_back(16'd2); q_node.push_back(16'd3); q_node.push_back(16'd4);
    for (int i = 0; i < 3; i++) q_wegt.push_back(pack4(1, -1, 2, -5));
  endtask

  task automatic load_random(input int n);
    q_node.delete(); q_wegt.delete();
    for (int i = 0; i < n; i++) begin
      q_node.push_back(W'($urandom));
      q_wegt.push_back({$urandom, $urandom});
    end
  endtask

  initial begin
    model_reset();
    cycle();
    cycle();
    chk("reset_idle", longint'(o_idle), 1);
    chk("reset_result", longint'(o_result), 0);
    #2 reset_n = 1'b1;

    load_basic();
    run_job(3, 1'b0, 0, pack4(5, 0, 0, 0), 0, 1'b0, 1'b0);
    chk_lane("basic_l0", 0, 14);
    chk_lane("basic_l1", 1, -9);
    run_job(3, 1'b1, 0, pack4(5, 0, 0, 0), 0, 1'b0, 1'b0);
    chk_lane("relu_l0", 0, 14);
    chk_lane("relu_l1", 1, 0);

    q_node.delete(); q_wegt.delete();
    for (int i = 0; i < 2; i++) begin
      q_node.push_back(16'd32767);
      q_wegt.push_back(pack4(32767, -32767, 1, 0));
    end
    run_job(2, 1'b0, 0, pack4(0, 0, 0, 0), 0, 1'b0, 1'b0);
    chk_lane("sat_pos", 0, 32767);
    chk_lane("sat_neg", 1, -32768);
    run_job(2, 1'b0, 16, pack4(0, 0, 0, 0), 0, 1'b0, 1'b0);
    chk_lane("shift16", 0, 32766);

    load_basic();
    run_job(3, 1'b0, 0, pack4(5, 0, 0, 0), 50, 1'b1, 1'b0);
    chk_lane("stall_l0", 0, 14);
    chk_lane("stall_l1", 1, -9);

    run_job(0, 1'b0, 0, pack4(7, -3, 0, 100), 0, 1'b1, 1'b0);
    chk_lane("n0_l0", 0, 7);
    chk_lane("n0_l1", 1, -3);
    chk_lane("n0_l2", 2, 0);
    chk_lane("n0_l3", 3, 100);

    // Asynchronous reset in the middle of a job.
    @(negedge clk);
    load_random(5);
    i_run = 1'b1; i_num_inputs = 12'd5; i_bias = pack4(1, 2, 3, 4);
    cycle();
    i_run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_node = q_node[i]; i_wegt = q_wegt[i];
      cycle();
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_result", longint'(o_result), 0);
    chk("rst_idle", longint'(o_idle), 1);
    chk("rst_ready", longint'(o_ready), 0);
    model_reset();
    i_valid = 1'b0;
    cycle();
    #2 reset_n = 1'b1;
    load_basic();
    run_job(3, 1'b0, 0, pack4(5, 0, 0, 0), 0, 1'b0, 1'b0);
    chk_lane("post_rst_l0", 0, 14);
    chk_lane("post_rst_l1", 1, -9);

    run_job(3, 1'b0, 0, pack4(5, 0, 0, 0), 30, 1'b0, 1'b1);
    chk_lane("noise_l0", 0, 14);
    chk_lane("noise_l1", 1, -9);
    run_job(3, 1'b1, 0, pack4(5, 0, 0, 0), 0, 1'b0, 1'b0);
    chk_lane("b2b_l1", 1, 0);

    for (int j = 0; j < 30; j++) begin
      int n;
      n = int'($urandom_range(0, 20));
      load_random(n);
      run_job(n, 1'($urandom), int'($urandom_range(0, 31)), {$urandom, $urandom},
              int'($urandom_range(0, 60)), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fc_mac_array.md
# fc_mac_array

Parametrised multi-lane fully-connected MAC engine, the next generation of the single-lane FC core. It computes NUM_LANES neurons in parallel from one shared input-node stream and per-lane weights. Each job accumulates a programmed number of input beats, then adds bias once per job. Optional ReLU, arithmetic right shift and saturation follow, and the block emits one valid-qualified result vector. It sits between the feature/weight buffer readers and the layer output writer.

## Interface
- IN_DATA_WIDTH, 16, signed width of node, weight and bias
- NUM_LANES, 4, parallel output neurons
- CNT_WIDTH, 12, width of beat counter / i_num_inputs
- ACC_WIDTH, 2*IN_DATA_WIDTH+CNT_WIDTH, signed accumulator width
- OUT_DATA_WIDTH, 16, signed output width per lane
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_run  in  1  job start; sampled only in IDLE
- i_num_inputs  in  CNT_WIDTH  beats N in job; latched on accepted i_run
- i_relu_en  in  1  ReLU enable; latched on accepted i_run
- i_shift  in  5  arithmetic right-shift amount; latched on accepted i_run
- i_bias  in  NUM_LANES*IN_DATA_WIDTH  per-lane bias, lane k at [k*IN_DATA_WIDTH +: IN_DATA_WIDTH]; latched on accepted i_run
- i_valid  in  1  input beat valid
- o_ready  out  1  beat can be accepted
- i_node  in  IN_DATA_WIDTH  signed node value, shared by all lanes
- i_wegt  in  NUM_LANES*IN_DATA_WIDTH  signed per-lane weights, same packing as i_bias
- o_valid  out  1  one-cycle result strobe
- o_result  out  NUM_LANES*OUT_DATA_WIDTH  signed per-lane results, lane k at [k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]
- o_idle  out  1  high in IDLE

## Operation
- States: IDLE, ACCUM, DRAIN1, DRAIN2; OUT handled as the DRAIN2->IDLE transition.
- IDLE: o_idle=1. i_run=1 latches the config, clears the beat counter, the accumulators and the product registers, then -> ACCUM. i_run is ignored in all other states.
- ACCUM: o_ready = (cnt != N). A beat is accepted when i_valid & o_ready; cnt increments on acceptance. i_valid with o_ready=0 is ignored.
- When cnt == N in ACCUM -> DRAIN1 -> DRAIN2 -> IDLE. N=0 passes through ACCUM for one cycle with o_ready=0.
- Pipeline per lane: stage 1 registers the signed product node*wegt (2*IN_DATA_WIDTH) with a valid bit. Stage 2 adds the sign-extended product to the accumulator. The accumulator wraps in two's complement; the default ACC_WIDTH cannot overflow.
- Post-process on the DRAIN2->IDLE edge, per lane:
  - sum = acc + sign-extended bias
  - if relu_en and sum<0, sum = 0
  - sum >>> shift (floor)
  - saturate to [-2^(OUT_DATA_WIDTH-1), 2^(OUT_DATA_WIDTH-1)-1]
  - register into o_result and assert o_valid for exactly one cycle.
- o_result holds its value until the next o_valid. It is not cleared by i_run.

## Timing
- Reset (async, any state): state=IDLE, o_idle=1, o_ready=0, o_valid=0, o_result=0, accumulators/products/counter/config=0. In-flight job is discarded; first new i_run after deassertion behaves normally.
- i_run sampled at edge e0: ACCUM from e0, o_ready=1 in the cycle after e0 (if N>0).
- Last beat accepted at edge eL: o_ready=0 from eL. o_valid=1 and o_result updated at edge eL+3, i.e. latency 3 cycles from last accept.
- N=0: o_valid at e0+3, o_result = post-processed bias.
- o_idle=1 in the same cycle o_valid=1; i_run may be asserted then and is sampled at the next edge. Back-to-back jobs have 1 idle cycle minimum.
- Beats may have arbitrary gaps (i_valid low); the result is independent of gap pattern.

## Test plan
- N=3, node {2,3,4}, lane0 wegt {1,1,1} bias 5, lane1 wegt {-1,-1,-1} bias 0, shift 0, relu off -> lane0=14, lane1=-9. Repeat with relu on -> lane1=0. o_valid exactly 3 cycles after last accept.
- Saturation/shift: N=2, node 32767, wegt 32767, bias 0. Shift 0 -> 32767; wegt -32767 -> -32768; wegt 32767 with shift 16 -> 32766.
- Stalls: same vectors as the first test with random i_valid gaps, plus i_valid held high after N beats -> identical results, extra beats not accepted (o_ready=0).
- N=0 with biases {7,-3,0,100} -> o_result {7,-3,0,100} at e0+3, no beat accepted.
- reset_n pulsed low mid-ACCUM -> all outputs 0, o_idle=1 immediately. Subsequent job with the first test's vectors gives 14/-9.
- i_run pulsed during ACCUM/DRAIN -> ignored, result unchanged. Second i_run in the o_valid cycle starts a new job whose result is correct.
